// File: rtl/program_loader.sv
// program_loader: parses framed host bytes into byte writes of the 256-byte instruction memory
module program_loader #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] byte_i,
   input  logic       byte_valid_i,
   output logic       byte_ready_o,
   output logic       we_o,
   output logic [7:0] waddr_o,
   output logic [7:0] wdata_o,
   output logic       hold_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o,
   output logic [1:0] error_code_o
);
   typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM} state_t;
   state_t      state, state_n;
   logic [7:0]  ptr, ptr_n, sum, sum_n, waddr_n, wdata_n;
   logic [8:0]  cnt, cnt_n;
   logic [15:0] tcnt, tcnt_n;
   logic        acc, expire, we_n, done_n, err_n;
   logic [1:0]  code_n;
   assign acc    = byte_valid_i & byte_ready_o;
   assign expire = (state != IDLE) & ~acc & (tcnt == 16'(TIMEOUT_CYCLES - 1));
   // frame parser: next state, pointer/count/sum and next registered outputs
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      sum_n   = sum;
      cnt_n   = cnt;
      tcnt_n  = (state == IDLE || acc) ? 16'd0 : tcnt + 16'd1;
      we_n    = 1'b0;
      waddr_n = waddr_o;
      wdata_n = wdata_o;
      done_n  = 1'b0;
      err_n   = error_o;
      code_n  = error_code_o;
      case (state)
         IDLE: if (acc && byte_i == 8'hA5) begin
            state_n = ADDR;
            err_n   = 1'b0;
            code_n  = 2'b00;
         end
         ADDR: if (acc) begin
            ptr_n   = byte_i;
            sum_n   = byte_i;
            state_n = LEN;
         end
         LEN: if (acc) begin
            cnt_n   = {byte_i == 8'h00, byte_i};
            sum_n   = sum + byte_i;
            state_n = DATA;
         end
         DATA: if (acc) begin
            we_n    = 1'b1;
            waddr_n = ptr;
            wdata_n = byte_i;
            ptr_n   = ptr + 8'd1;
            sum_n   = sum + byte_i;
            cnt_n   = cnt - 9'd1;
            state_n = (cnt == 9'd1) ? CSUM : DATA;
         end
         CSUM: if (acc) begin
            state_n = IDLE;
            done_n  = 1'b1;
            err_n   = (byte_i != sum);
            code_n  = (byte_i != sum) ? 2'b01 : 2'b00;
         end
         default: state_n = IDLE;
      endcase
      if (expire) begin
         state_n = IDLE;
         tcnt_n  = 16'd0;
         done_n  = 1'b1;
         err_n   = 1'b1;
         code_n  = 2'b10;
      end
   end
   // state and output registers; hold/busy track the frame so they fall with done
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         ptr          <= '0;
         sum          <= '0;
         cnt          <= '0;
         tcnt         <= '0;
         byte_ready_o <= 1'b0;
         we_o         <= 1'b0;
         waddr_o      <= '0;
         wdata_o      <= '0;
         hold_o       <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
         error_code_o <= 2'b00;
      end else begin
         state        <= state_n;
         ptr          <= ptr_n;
         sum          <= sum_n;
         cnt          <= cnt_n;
         tcnt         <= tcnt_n;
         byte_ready_o <= 1'b1;
         we_o         <= we_n;
         waddr_o      <= waddr_n;
         wdata_o      <= wdata_n;
         hold_o       <= (state_n != IDLE);
         busy_o       <= (state_n != IDLE);
         done_o       <= done_n;
         error_o      <= err_n;
         error_code_o <= code_n;
      end
   end
endmodule
